// File: rtl/proc_control_fsm.sv
// Multicycle control unit for the 16-bit simple processor: steps T0..T3 per
// instruction and drives register enables, bus selects, ALU op and Done.
module proc_control_fsm #(
    parameter int IR_W = 9,
    parameter int NREG = 8
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            Run,
    input  logic [IR_W-1:0] IR,
    input  logic            Gnz,
    output logic            IRin,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic            DINout,
    output logic [1:0]      AluOp,
    output logic            Done
);

    typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_MVNZ = 3'b101,
        OP_NOP0 = 3'b110,
        OP_NOP1 = 3'b111
    } op_t;

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    tstep_t          state;
    tstep_t          state_next;
    op_t             op;
    logic [NREG-1:0] rx_sel;
    logic [NREG-1:0] ry_sel;
    logic            is_alu;

    assign op     = op_t'(IR[8:6]);
    assign rx_sel = ONE << IR[5:3];
    assign ry_sel = ONE << IR[2:0];
    assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            state <= T0;
        else
            state <= state_next;
    end

    // Outputs are forced low while in reset so that IRin cannot follow Run.
    always_comb begin
        state_next = T0;
        IRin       = 1'b0;
        Rin        = '0;
        Rout       = '0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        Gout       = 1'b0;
        DINout     = 1'b0;
        AluOp      = 2'b00;
        Done       = 1'b0;
        if (Resetn) begin
            case (state)
                T0: begin
                    IRin       = Run;
                    state_next = Run ? T1 : T0;
                end
                T1: begin
                    case (op)
                        OP_MV: begin
                            Rout = ry_sel;
                            Rin  = rx_sel;
                            Done = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            Rin    = rx_sel;
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            Rout       = rx_sel;
                            Ain        = 1'b1;
                            state_next = T2;
                        end
                        OP_MVNZ: begin
                            if (Gnz) begin
                                Rout = ry_sel;
                                Rin  = rx_sel;
                            end
                            Done = 1'b1;
                        end
                        default: Done = 1'b1;
                    endcase
                end
                T2: begin
                    if (is_alu) begin
                        Rout       = ry_sel;
                        Gin        = 1'b1;
                        state_next = T3;
                        case (op)
                            OP_SUB:  AluOp = 2'b01;
                            OP_AND:  AluOp = 2'b10;
                            default: AluOp = 2'b00;
                        endcase
                    end
                end
                T3: begin
                    if (is_alu) begin
                        Gout = 1'b1;
                        Rin  = rx_sel;
                        Done = 1'b1;
                    end
                end
                default: state_next = T0;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm: each task walks one instruction
// scenario cycle by cycle and compares the full output vector.
module tb_proc_control_fsm;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Run;
    logic [8:0] IR;
    logic       Gnz;
    logic       IRin;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic       DINout;
    logic [1:0] AluOp;
    logic       Done;

    int checks = 0;
    int errors = 0;

    logic [23:0] outs;
    logic [23:0] e;

    proc_control_fsm #(.IR_W(9), .NREG(8)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR), .Gnz(Gnz),
        .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin),
        .Gout(Gout), .DINout(DINout), .AluOp(AluOp), .Done(Done)
    );

    always #5 Clock = ~Clock;

    assign outs = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AluOp, Done};

    function automatic logic [23:0] ev(input logic irin, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic ain,
                                       input logic gin, input logic gout,
                                       input logic din, input logic [1:0] aop,
                                       input logic done);
        return {irin, rin, rout, ain, gin, gout, din, aop, done};
    endfunction

    // Advance to just after the next rising edge; inputs are driven from here.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0; Run = 1'b1; IR = 9'b010_001_010; Gnz = 1'b0;
        #2;
        checks++; e = '0;
        if (outs !== e) begin errors++; $display("FAIL reset_initial: got %h want %h", outs, e); end
        tick(); tick();
        Resetn = 1'b1;
        #1;
        checks++; e = ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        if (outs !== e) begin errors++; $display("FAIL add_t0: got %h want %h", outs, e); end
        tick();
        #1;
        checks++; e = ev(0, 0, 8'b0000_0010, 1, 0, 0, 0, 2'b00, 0);
        if (outs !== e) begin errors++; $display("FAIL add_t1: got %h want %h", outs, e); end
        tick();
        #1;
        checks++; e = ev(0, 0, 8'b0000_0100, 0, 1, 0, 0, 2'b00, 0);
        if (outs !== e) begin errors++; $display("FAIL add_t2: got %h want %h", outs, e); end
        Resetn = 1'b0;
        #1;
        checks++; e = '0;
        if (outs !== e) begin errors++; $display("FAIL reset_mid_t2: got %h want %h", outs, e); end
        tick();
        checks++;
        if (outs !== e) begin errors++; $display("FAIL reset_held: got %h want %h", outs, e); end
        Resetn = 1'b1;
        #1;
        checks++; e = ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        if (outs !== e) begin errors++; $display("FAIL reset_release_t0: got %h want %h", outs, e); end
        Run = 1'b0;
        #1;
        checks++; e = '0;
        if (outs !== e) begin errors++; $display("FAIL reset_release_run0: got %h want %h", outs, e); end
        tick();
        #1;
        checks++;
        if (outs !== e) begin errors++; $display("FAIL idle_t0: got %h want %h", outs, e); end
    endtask

    task automatic test_mvi();
        Run = 1'b1; IR = 9'b001_011_000;
        #1;
        checks++; e = ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        if (outs !== e) begin errors++; $display("FAIL mvi_t0: got %h want %h", outs, e); end
        tick(); Run = 1'b0;
        #1;
        checks++; e = ev(0, 8'b0000_1000, 0, 0, 0, 0, 1, 2'b00, 1);
        if (outs !== e) begin errors++; $display("FAIL mvi_t1: got %h want %h", outs, e); end
        tick();
        #1;
        checks++; e = '0;
        if (outs !== e) begin errors++; $display("FAIL mvi_back_t0: got %h want %h", outs, e); end
    endtask

    task automatic test_sub();
        Run = 1'b1; IR = 9'b011_010_101;
        #1;
        tick(); Run = 1'b0;
        #1;
        checks++; e = ev(0, 0, 8'b0000_0100, 1, 0, 0, 0, 2'b00, 0);
        if (outs !== e) begin errors++; $display("FAIL sub_t1: got %h want %h", outs, e); end
        tick();
        #1;
        checks++; e = ev(0, 0, 8'b0010_0000, 0, 1, 0, 0, 2'b01, 0);
        if (outs !== e) begin errors++; $display("FAIL sub_t2: got %h want %h", outs, e); end
        tick();
        #1;
        checks++; e = ev(0, 8'b0000_0100, 0, 0, 0, 1, 0, 2'b00, 1);
        if (outs !== e) begin errors++; $display("FAIL sub_t3: got %h want %h", outs, e); end
        tick();
        #1;
        checks++; e = '0;
        if (outs !== e) begin errors++; $display("FAIL sub_back_t0: got %h want %h", outs, e); end
    endtask

    task automatic test_mvnz();
        Run = 1'b1; IR = 9'b101_001_110; Gnz = 1'b0;
        #1;
        tick(); Run = 1'b0;
        #1;
        checks++; e = ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
        if (outs !== e) begin errors++; $display("FAIL mvnz_gnz0: got %h want %h", outs, e); end
        tick();
        #1;
        checks++; e = '0;
        if (outs !== e) begin errors++; $display("FAIL mvnz_back_t0: got %h want %h", outs, e); end
        Run = 1'b1; Gnz = 1'b1;
        #1;
        tick(); Run = 1'b0;
        #1;
        checks++; e = ev(0, 8'b0000_0010, 8'b0100_0000, 0, 0, 0, 0, 2'b00, 1);
        if (outs !== e) begin errors++; $display("FAIL mvnz_gnz1: got %h want %h", outs, e); end
        tick(); Gnz = 1'b0;
        #1;
    endtask

    task automatic test_run_toggle();
        Run = 1'b1; IR = 9'b100_111_000;
        #1;
        tick(); Run = 1'b0;
        #1;
        checks++; e = ev(0, 0, 8'b1000_0000, 1, 0, 0, 0, 2'b00, 0);
        if (outs !== e) begin errors++; $display("FAIL and_t1: got %h want %h", outs, e); end
        tick(); Run = 1'b1;
        #1;
        checks++; e = ev(0, 0, 8'b0000_0001, 0, 1, 0, 0, 2'b10, 0);
        if (outs !== e) begin errors++; $display("FAIL and_t2_run1: got %h want %h", outs, e); end
        tick(); Run = 1'b0;
        #1;
        checks++; e = ev(0, 8'b1000_0000, 0, 0, 0, 1, 0, 2'b00, 1);
        if (outs !== e) begin errors++; $display("FAIL and_t3: got %h want %h", outs, e); end
        tick();
        #1;
        checks++; e = '0;
        if (outs !== e) begin errors++; $display("FAIL and_back_t0: got %h want %h", outs, e); end
    endtask

    task automatic test_back_to_back();
        Run = 1'b1; IR = 9'b000_100_100;
        #1;
        tick();
        #1;
        checks++; e = ev(0, 8'b0001_0000, 8'b0001_0000, 0, 0, 0, 0, 2'b00, 1);
        if (outs !== e) begin errors++; $display("FAIL b2b_mv_self: got %h want %h", outs, e); end
        tick(); IR = 9'b110_000_000;
        #1;
        checks++; e = ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        if (outs !== e) begin errors++; $display("FAIL b2b_irin_after_done: got %h want %h", outs, e); end
        tick();
        #1;
        checks++; e = ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
        if (outs !== e) begin errors++; $display("FAIL b2b_nop110: got %h want %h", outs, e); end
        tick(); IR = 9'b111_010_011;
        #1;
        checks++; e = ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        if (outs !== e) begin errors++; $display("FAIL b2b_irin_2: got %h want %h", outs, e); end
        tick(); Run = 1'b0;
        #1;
        checks++; e = ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
        if (outs !== e) begin errors++; $display("FAIL b2b_nop111: got %h want %h", outs, e); end
        tick();
        #1;
    endtask

    task automatic test_all_opcodes();
        int cycles;
        int want;
        logic [8:0] ir_v;
        for (int op = 0; op < 8; op++) begin
            for (int rep = 0; rep < 2; rep++) begin
                ir_v = {3'(op), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
                IR = ir_v; Gnz = 1'($urandom_range(0, 1)); Run = 1'b1;
                want = (op >= 2 && op <= 4) ? 4 : 2;
                cycles = 1;
                #1;
                checks++;
                if (IRin !== 1'b1) begin errors++; $display("FAIL sweep_irin op=%0d: got %b want 1", op, IRin); end
                do begin
                    tick(); Run = 1'b0;
                    #1;
                    cycles++;
                    checks++;
                    if ($countones({Rout, Gout, DINout}) > 1) begin
                        errors++; $display("FAIL sweep_bus ir=%b: got %b want at most one", ir_v, {Rout, Gout, DINout});
                    end
                    checks++;
                    if (!$onehot0(Rin)) begin
                        errors++; $display("FAIL sweep_rin ir=%b: got %b want zero/one-hot", ir_v, Rin);
                    end
                    checks++;
                    if (!Gin && AluOp !== 2'b00) begin
                        errors++; $display("FAIL sweep_aluop ir=%b: got %b want 00", ir_v, AluOp);
                    end
                end while (Done !== 1'b1 && cycles < 8);
                checks++;
                if (cycles !== want) begin
                    errors++; $display("FAIL sweep_latency ir=%b: got %0d want %0d", ir_v, cycles, want);
                end
                tick();
                #1;
            end
        end
        Gnz = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_sub();
        test_mvnz();
        test_run_toggle();
        test_back_to_back();
        test_all_opcodes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
- Multicycle control unit for the 16-bit simple processor.
- Sequences the register file (R0..R7, 16-bit), the A and G registers and the 9-bit instruction register (IR) over a shared 16-bit bus.
- Decodes IR format III XXX YYY (opcode, Rx, Ry) and steps through timesteps T0..T3.
- Drives register load enables, bus-source selects, ALU op and Done.

Parameters:
- IR_W, 9, instruction register width. The field layout [8:6]=III, [5:3]=XXX, [2:0]=YYY is fixed.
- NREG, 8, number of general registers. Fixed by the 3-bit register fields.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  start request; sampled only in T0.
- IR  in  9  current instruction, from the instruction register output.
- Gnz  in  1  G register is non-zero (supplied by the datapath).
- IRin  out  1  load enable of the instruction register (IR loads from DIN).
- Rin  out  8  one-hot load enables for R0..R7.
- Rout  out  8  one-hot bus drive selects for R0..R7.
- Ain  out  1  load enable of the A register.
- Gin  out  1  load enable of the G register.
- Gout  out  1  G drives the bus.
- DINout  out  1  DIN drives the bus.
- AluOp  out  2  00 add, 01 sub, 10 and; 11 is never driven.
- Done  out  1  final cycle of the current instruction.

Behaviour:
- State is a 2-bit timestep register: T0, T1, T2, T3. All outputs are combinational from the timestep and IR (plus Run in T0 and Gnz in T1).
- Reset: asynchronous to T0. While Resetn=0, every output is 0, IRin included.
- A reset mid-instruction aborts it. No enable is asserted afterwards, and the next instruction restarts from T0.
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#D (immediate supplied on DIN)
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 100 and Rx,Ry
  - 101 mvnz Rx,Ry
  - 110, 111 NOP
- T0: IRin=Run. If Run=1, go to T1; otherwise stay in T0. No other outputs are asserted. Done=0.
- T1:
  - mv: Rout[Y]=1, Rin[X]=1, Done=1.
  - mvi: DINout=1, Rin[X]=1, Done=1.
  - add/sub/and: Rout[X]=1, Ain=1.
  - mvnz: if Gnz=1, Rout[Y]=1 and Rin[X]=1; Done=1 regardless of Gnz.
  - NOP: Done=1 only.
- T2 (ALU ops only): Rout[Y]=1, Gin=1, AluOp = 00 for add, 01 for sub, 10 for and.
- T3 (ALU ops only): Gout=1, Rin[X]=1, Done=1.
- Next state:
  - If Done=1, go to T0.
  - Otherwise T1 goes to T2 and T2 goes to T3.
  - T2/T3 are reachable only by ALU opcodes. Any other state/opcode combination goes to T0 with all outputs 0.
- Latency, counting from the T0 cycle with Run=1: mv/mvi/mvnz/NOP take 2 cycles; add/sub/and take 4 cycles.
- Bus rule: in every cycle at most one of {Rout bits, Gout, DINout} is 1.
- Rin is zero-hot or one-hot. Rx=Ry is legal; for mv this is a self-copy.
- Run is ignored outside T0. Holding Run high gives back-to-back instructions: T0 follows the Done cycle immediately.
- AluOp is 00 whenever Gin=0.

Test Plan:
- Reset low during T2 of an add → all outputs 0 while low. After release: T0, and IRin follows Run.
- Run=1, IR=001_011_000 (mvi R3) → T0: IRin=1; next cycle: DINout=1, Rin=8'b00001000, Done=1; then back to T0.
- IR=011_010_101 (sub R2,R5) → T1: Rout=00000100, Ain=1; T2: Rout=00100000, Gin=1, AluOp=01; T3: Gout=1, Rin=00000100, Done=1.
- IR=101_001_110 (mvnz R1,R6) with Gnz=0 → T1: Done=1, Rin=0, Rout=0. With Gnz=1 → Rout=01000000, Rin=00000010, Done=1.
- Run toggled during T1–T3 of an and → no effect on the sequence. Run held high → the next IRin occurs in the cycle after Done.
- All 8 opcodes × random Rx/Ry → assert bus exclusivity, Rin one-hot-or-zero, and a cycle count of 2 or 4 per opcode.
